maze_move_ctrl: RTL
===================

# maze_move_ctrl

Player-movement and room-sequencing controller for the meikyuu maze game. Once per video frame it turns the direction buttons into a candidate player position and runs a collision handshake with the room renderer. It then commits the move, or performs a room change across the 3x3 maze map with a blanking interval. It owns the authoritative player position, current room coordinates and win flag consumed by the VGA renderer.

## Interface
Parameters:
- STEP, 2, pixels moved per accepted frame
- COLL_LAT, 2, cycles from cand_valid rise to collision sample (1..7)
- BLANK_FRAMES, 8, frames of blank after a room change (1..15)
- X_MIN, 96; X_MAX, 720; Y_MIN, 2; Y_MAX, 466, inclusive legal x_pos/y_pos range
- X_START, 408; Y_START, 234, reset position
- GOAL_X, 2; GOAL_Y, 2, goal room

Ports:
- CLOCK_50  in  1  system clock
- reset  in  1  asynchronous, active-high
- frame_tick  in  1  one-cycle pulse per frame, synchronous to CLOCK_50
- btn_up, btn_down, btn_left, btn_right  in  1 each  active-high, already synchronized
- collision  in  1  renderer verdict for cand_x/cand_y, valid COLL_LAT cycles after cand_valid rises
- cand_x, cand_y  out  10 each  candidate position under test
- cand_valid  out  1  candidate held stable while high
- x_pos, y_pos  out  10 each  committed player position
- room_x, room_y  out  2 each  current room, 0..2
- blank  out  1  renderer draws black while high
- win  out  1  sticky goal-reached flag

## Operation
- Reset values: x_pos=X_START, y_pos=Y_START, room_x=room_y=0, cand_x=cand_y=0, cand_valid=0, blank=0, win=0, state IDLE, all counters 0.
- States: IDLE, PROPOSE, CHECK, ROOM_CHANGE, WIN.
- IDLE: frame_tick=1 -> PROPOSE. Buttons are ignored outside PROPOSE.
- PROPOSE: one axis per frame. Priority is up > down > left > right.
  - up: y-STEP; down: y+STEP; left: x-STEP; right: x+STEP.
  - Arithmetic in 11-bit signed, so underflow below 0 is detected.
  - No button -> IDLE.
  - Candidate inside [X_MIN,X_MAX]x[Y_MIN,Y_MAX] -> load cand_x/cand_y, cand_valid=1, go to CHECK.
  - Candidate outside, and the adjacent room exists (room index stays within 0..2) -> ROOM_CHANGE.
  - Candidate outside, and no adjacent room exists -> move blocked, position unchanged, go to IDLE.
- CHECK: counter runs COLL_LAT cycles, then collision is sampled.
  - collision=0 -> x_pos/y_pos<=cand.
  - collision=1 -> position unchanged.
  - Either way cand_valid<=0 and the state goes to IDLE.
- ROOM_CHANGE entry (same edge as leaving PROPOSE):
  - Room index steps by ±1.
  - Exit left -> x_pos=X_MAX; right -> x_pos=X_MIN; up -> y_pos=Y_MAX; down -> y_pos=Y_MIN. The other coordinate is unchanged.
  - If the new room equals (GOAL_X,GOAL_Y): win<=1, state WIN, blank stays 0.
  - Otherwise blank<=1 and the frame counter is cleared.
- ROOM_CHANGE: each frame_tick increments the counter. On the tick that makes the count equal BLANK_FRAMES: blank<=0, go to IDLE. That tick does not start a move.
- WIN: terminal. Outputs are frozen and frame_tick and buttons are ignored until reset.
- The room change needs no collision check. Walls reach the screen edge, so an edge can only be crossed through an opening.

## Timing
- frame_tick sampled in IDLE at edge T -> PROPOSE at T.
- The PROPOSE decision registers at edge T+1: cand_valid rises, or the room/position change, or the block returns to IDLE.
- Collision is sampled and the position committed at edge T+1+COLL_LAT, where cand_valid also falls. Default: 3 cycles from the tick.
- cand_x/cand_y/cand_valid are constant for the whole CHECK window. collision is ignored outside the sample edge.
- A frame_tick arriving in PROPOSE or CHECK is dropped, not queued. One move per frame at most.
- Asynchronous reset at any point, including mid-CHECK or mid-blank, forces all reset values immediately. No partial commit.
- blank is high from edge T+1 until the edge of the BLANK_FRAMES-th following frame_tick.

## Test plan
- Reset, pulse frame_tick with btn_right, collision=0 -> cand_valid high edges T+1..T+2; x_pos 408->410 at T+3; y_pos 234.
- btn_up+btn_left together, collision=1 -> cand_y=232, cand_x=408; position unchanged; state back in IDLE.
- Room (0,0), x_pos=720, btn_right -> room_x=1, x_pos=96, blank=1. blank clears on the 8th subsequent frame_tick. Ticks during blank cause no moves.
- Room (0,0), x_pos=96, btn_left -> blocked: x_pos=96, room_x=0, blank=0, cand_valid never rises.
- Room (2,1), y_pos=466, btn_down -> room_y=2, win=1, y_pos=2, blank=0. Later ticks and buttons change nothing.
- Assert reset during CHECK and during blank -> all outputs at reset values the same cycle. The next frame_tick with btn_down yields y_pos=236.

Source files
------------

// File: rtl/maze_move_ctrl.sv
// Per-frame player movement, collision handshake with the renderer and room
// sequencing across the 3x3 maze map; owns position, room, blank and win state.
module maze_move_ctrl #(
  parameter int unsigned STEP         = 2,
  parameter int unsigned COLL_LAT     = 2,
  parameter int unsigned BLANK_FRAMES = 8,
  parameter int unsigned X_MIN        = 96,
  parameter int unsigned X_MAX        = 720,
  parameter int unsigned Y_MIN        = 2,
  parameter int unsigned Y_MAX        = 466,
  parameter int unsigned X_START      = 408,
  parameter int unsigned Y_START      = 234,
  parameter int unsigned GOAL_X       = 2,
  parameter int unsigned GOAL_Y       = 2
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       collision,
  output logic [9:0] cand_x,
  output logic [9:0] cand_y,
  output logic       cand_valid,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic [1:0] room_x,
  output logic [1:0] room_y,
  output logic       blank,
  output logic       win
);
  localparam int unsigned PW = 10;
  localparam int unsigned SW = 11;
  localparam int unsigned RW = 2;
  localparam int unsigned CW = 3;
  localparam int unsigned FW = 4;

  typedef enum logic [2:0] {
    S_IDLE, S_PROPOSE, S_CHECK, S_ROOM_CHANGE, S_WIN
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] x_q, x_d, y_q, y_d;
  logic [PW-1:0] cand_x_q, cand_x_d, cand_y_q, cand_y_d;
  logic [RW-1:0] room_x_q, room_x_d, room_y_q, room_y_d;
  logic          cand_valid_q, cand_valid_d;
  logic          blank_q, blank_d;
  logic          win_q, win_d;
  logic [CW-1:0] lat_cnt_q, lat_cnt_d;
  logic [FW-1:0] frm_cnt_q, frm_cnt_d;

  logic signed [SW-1:0] tx_c, ty_c;
  logic [PW-1:0]        edge_x_c, edge_y_c;
  logic [RW-1:0]        new_rx_c, new_ry_c;
  logic                 any_btn_c, in_range_c, adj_ok_c, goal_c;

  // Candidate for the highest-priority button, plus the room-exit alternative.
  always_comb begin : candidate
    tx_c     = $signed({1'b0, x_q});
    ty_c     = $signed({1'b0, y_q});
    edge_x_c = x_q;
    edge_y_c = y_q;
    new_rx_c = room_x_q;
    new_ry_c = room_y_q;
    adj_ok_c = 1'b0;
    if (btn_up) begin
      ty_c     = ty_c - $signed(SW'(STEP));
      adj_ok_c = (room_y_q != 2'd0);
      new_ry_c = room_y_q - 2'd1;
      edge_y_c = PW'(Y_MAX);
    end else if (btn_down) begin
      ty_c     = ty_c + $signed(SW'(STEP));
      adj_ok_c = (room_y_q != 2'd2);
      new_ry_c = room_y_q + 2'd1;
      edge_y_c = PW'(Y_MIN);
    end else if (btn_left) begin
      tx_c     = tx_c - $signed(SW'(STEP));
      adj_ok_c = (room_x_q != 2'd0);
      new_rx_c = room_x_q - 2'd1;
      edge_x_c = PW'(X_MAX);
    end else if (btn_right) begin
      tx_c     = tx_c + $signed(SW'(STEP));
      adj_ok_c = (room_x_q != 2'd2);
      new_rx_c = room_x_q + 2'd1;
      edge_x_c = PW'(X_MIN);
    end
    any_btn_c  = btn_up | btn_down | btn_left | btn_right;
    in_range_c = (tx_c >= $signed(SW'(X_MIN))) && (tx_c <= $signed(SW'(X_MAX))) &&
                 (ty_c >= $signed(SW'(Y_MIN))) && (ty_c <= $signed(SW'(Y_MAX)));
    goal_c     = (new_rx_c == RW'(GOAL_X)) && (new_ry_c == RW'(GOAL_Y));
  end

  // Next-state and register updates.
  always_comb begin : fsm_next
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    cand_x_d     = cand_x_q;
    cand_y_d     = cand_y_q;
    cand_valid_d = cand_valid_q;
    room_x_d     = room_x_q;
    room_y_d     = room_y_q;
    blank_d      = blank_q;
    win_d        = win_q;
    lat_cnt_d    = lat_cnt_q;
    frm_cnt_d    = frm_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (frame_tick) state_d = S_PROPOSE;
      end
      S_PROPOSE: begin
        state_d = S_IDLE;
        if (any_btn_c && in_range_c) begin
          cand_x_d     = tx_c[PW-1:0];
          cand_y_d     = ty_c[PW-1:0];
          cand_valid_d = 1'b1;
          lat_cnt_d    = '0;
          state_d      = S_CHECK;
        end else if (any_btn_c && adj_ok_c) begin
          room_x_d = new_rx_c;
          room_y_d = new_ry_c;
          x_d      = edge_x_c;
          y_d      = edge_y_c;
          if (goal_c) begin
            win_d   = 1'b1;
            state_d = S_WIN;
          end else begin
            blank_d   = 1'b1;
            frm_cnt_d = '0;
            state_d   = S_ROOM_CHANGE;
          end
        end
      end
      S_CHECK: begin
        if (lat_cnt_q == CW'(COLL_LAT - 1)) begin
          if (!collision) begin
            x_d = cand_x_q;
            y_d = cand_y_q;
          end
          cand_valid_d = 1'b0;
          state_d      = S_IDLE;
        end else begin
          lat_cnt_d = lat_cnt_q + CW'(1);
        end
      end
      S_ROOM_CHANGE: begin
        if (frame_tick) begin
          if (frm_cnt_q == FW'(BLANK_FRAMES - 1)) begin
            blank_d   = 1'b0;
            frm_cnt_d = '0;
            state_d   = S_IDLE;
          end else begin
            frm_cnt_d = frm_cnt_q + FW'(1);
          end
        end
      end
      S_WIN: begin
        state_d = S_WIN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      x_q          <= PW'(X_START);
      y_q          <= PW'(Y_START);
      cand_x_q     <= '0;
      cand_y_q     <= '0;
      cand_valid_q <= 1'b0;
      room_x_q     <= '0;
      room_y_q     <= '0;
      blank_q      <= 1'b0;
      win_q        <= 1'b0;
      lat_cnt_q    <= '0;
      frm_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      cand_x_q     <= cand_x_d;
      cand_y_q     <= cand_y_d;
      cand_valid_q <= cand_valid_d;
      room_x_q     <= room_x_d;
      room_y_q     <= room_y_d;
      blank_q      <= blank_d;
      win_q        <= win_d;
      lat_cnt_q    <= lat_cnt_d;
      frm_cnt_q    <= frm_cnt_d;
    end
  end

  assign cand_x     = cand_x_q;
  assign cand_y     = cand_y_q;
  assign cand_valid = cand_valid_q;
  assign x_pos      = x_q;
  assign y_pos      = y_q;
  assign room_x     = room_x_q;
  assign room_y     = room_y_q;
  assign blank      = blank_q;
  assign win        = win_q;
endmodule
